// File: rtl/ex_multicycle_ctrl.sv
// ex_multicycle_ctrl
// Sequences the long-latency EX-stage resources. It handles the fixed-latency
// DIV/REM unit and the handshaked FP ALU, and raises the front-end stall while
// an operation is in flight. The stall drops in the completion cycle so the
// pipeline can latch the result. A MEM-stage flush aborts the operation at once.

module ex_multicycle_ctrl #(
    parameter int DIV_CYCLES  = 7,
    parameter int FPU_TIMEOUT = 63,
    parameter int CNT_W       = 6
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic iEX_DivRem,
    input  logic iEX_FPOp,
    input  logic iEX_Hold,
    input  logic iFlush,
    input  logic iFPU_Ready,
    output logic oDIV_Start,
    output logic oFPU_Start,
    output logic oStall,
    output logic oDone,
    output logic oBusy,
    output logic oTimeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        FPU_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] FPU_LAST = CNT_W'(FPU_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             done_seen;
    logic             done_seen_next;
    logic             timeout_q;
    logic             timeout_next;
    logic             div_start;
    logic             fpu_start;
    logic             stall;
    logic             done;

    // Saturating increment: the counter never wraps back to a compare point
    always_comb begin
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end

    // State, cycle counter, first-DONE marker and sticky timeout flag
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= IDLE;
            cnt       <= '0;
            done_seen <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            done_seen <= done_seen_next;
            timeout_q <= timeout_next;
        end
    end

    // Next-state and output decode; a flush outside IDLE beats every other transition
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        done_seen_next = done_seen;
        timeout_next   = timeout_q;
        div_start      = 1'b0;
        fpu_start      = 1'b0;
        stall          = 1'b0;
        done           = 1'b0;

        case (state)
            IDLE: begin
                cnt_next       = '0;
                done_seen_next = 1'b0;
                if (!iFlush) begin
                    if (iEX_DivRem) begin
                        div_start  = 1'b1;
                        stall      = 1'b1;
                        state_next = DIV_RUN;
                        cnt_next   = CNT_ONE;
                    end else if (iEX_FPOp) begin
                        fpu_start  = 1'b1;
                        stall      = 1'b1;
                        state_next = FPU_RUN;
                        cnt_next   = CNT_ONE;
                    end
                end
            end

            DIV_RUN: begin
                if (iFlush) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    stall = 1'b1;
                    if (cnt == DIV_LAST) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end

            FPU_RUN: begin
                if (iFlush) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    stall = 1'b1;
                    if (iFPU_Ready) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else if (cnt == FPU_LAST) begin
                        timeout_next = 1'b1;
                        state_next   = DONE;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end

            DONE: begin
                cnt_next = '0;
                if (iFlush) begin
                    state_next     = IDLE;
                    done_seen_next = 1'b0;
                end else begin
                    done           = !done_seen;
                    done_seen_next = 1'b1;
                    if (!iEX_Hold) begin
                        state_next     = IDLE;
                        done_seen_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pulses are forced low while reset is asserted so that every output reads 0
    always_comb begin
        oDIV_Start = div_start & iRST_n;
        oFPU_Start = fpu_start & iRST_n;
        oStall     = stall & iRST_n;
        oDone      = done & iRST_n;
        oBusy      = (state != IDLE);
        oTimeout   = timeout_q;
    end

endmodule

// File: doc/ex_multicycle_ctrl.md
Name: ex_multicycle_ctrl

Overview:
- Sequences the long-latency EX-stage resources: the DIV/REM unit (fixed latency, cycle-counted) and the FP ALU (start/ready handshake).
- Issues start pulses, raises the whole-front-end stall request (IF/ID/EX) while an operation is in flight, and signals completion.
- Aborts cleanly on a MEM-stage exception flush.
- Replaces the free-running divide counter on the 50 MHz clock with a single-clock controller that the forward/hazard unit ORs into its stall logic.

Parameters:
- DIV_CYCLES, 7, cycles the DIV/REM result needs after oDIV_Start; must be ≥1.
- FPU_TIMEOUT, 63, maximum cycles to wait for iFPU_Ready before forced completion with error.
- CNT_W, 6, counter width; must hold max(DIV_CYCLES, FPU_TIMEOUT).

Ports:
- iCLK  in  1  core clock.
- iRST_n  in  1  asynchronous active-low reset.
- iEX_DivRem  in  1  instruction in EX is DIV/DIVU/REM/REMU.
- iEX_FPOp  in  1  instruction in EX uses the FP ALU (FAIsInt or FAIsFloat).
- iEX_Hold  in  1  EX/MEM register held by a downstream stall; EX instruction does not advance.
- iFlush  in  1  MEM exception flush; kills the EX instruction.
- iFPU_Ready  in  1  FP ALU result valid (level, sampled each cycle).
- oDIV_Start  out  1  one-cycle start pulse to DIV/REM unit.
- oFPU_Start  out  1  one-cycle start pulse to FP ALU.
- oStall  out  1  stall request for IF, ID and EX.
- oDone  out  1  one-cycle pulse: result valid in EX this cycle.
- oBusy  out  1  state ≠ IDLE.
- oTimeout  out  1  sticky: an FPU op hit FPU_TIMEOUT; cleared only by reset.

Behaviour:
- Reset (async, iRST_n=0):
  - State goes to IDLE and the counter to 0.
  - All outputs are 0, including oTimeout.
  - Reset mid-operation abandons the op without issuing oDone.
- States: IDLE, DIV_RUN, FPU_RUN, DONE.
- IDLE:
  - iFlush=1: stay in IDLE, no start.
  - Else if iEX_DivRem=1: oDIV_Start=1 combinationally this cycle; oStall=1; next state DIV_RUN with cnt=1.
  - Else if iEX_FPOp=1: oFPU_Start=1; oStall=1; next state FPU_RUN with cnt=1.
  - If both are asserted, DIV/REM has priority (the decoder never asserts both; the bench checks the priority only).
- DIV_RUN:
  - oStall=1 and cnt increments each cycle.
  - When cnt==DIV_CYCLES: go to DONE. oStall stays 1 in that final cycle.
  - Total stall = DIV_CYCLES+1 cycles, including the start cycle.
- FPU_RUN:
  - oStall=1.
  - iFPU_Ready=1: go to DONE.
  - Else if cnt==FPU_TIMEOUT: set oTimeout and go to DONE.
  - Else cnt increments.
  - iFPU_Ready is ignored in the start cycle (IDLE).
- DONE:
  - oStall=0 and oDone=1, so the pipeline latches the result.
  - iEX_Hold=1: stay in DONE, keep oStall=0, and pulse oDone only on the first DONE cycle. The held instruction is never restarted.
  - iEX_Hold=0: go to IDLE.
  - A new DIV/FP instruction entering EX is seen in IDLE on the following cycle, so back-to-back long ops each get their own full sequence.
- iFlush in any non-IDLE state has priority over every other transition:
  - next state IDLE, cnt=0;
  - oStall=0 that same cycle (combinational) so the flush propagates;
  - no oDone.
- Counter: unsigned CNT_W bits, saturating. It never wraps; compare points are reached before saturation.
- Outputs oStall, oDIV_Start, oFPU_Start and oDone are Moore/Mealy combinations of the registered state plus IDLE/flush inputs. There is no combinational path from iFPU_Ready to oStall.

Test Plan:
- DIV basic: iEX_DivRem=1 at cycle 0 with DIV_CYCLES=7 → oDIV_Start high in cycle 0 only; oStall high cycles 0–7; oDone in cycle 8 with oStall=0; back to IDLE in cycle 9.
- FPU handshake: iEX_FPOp=1 at cycle 0, iFPU_Ready=1 at cycle 4 → oFPU_Start in cycle 0; oStall high cycles 0–4; oDone in cycle 5; oTimeout stays 0.
- FPU timeout: iEX_FPOp=1 with iFPU_Ready tied 0, FPU_TIMEOUT=63 → oStall high for 64 cycles; oDone in the next cycle; oTimeout=1 and remains 1 after further ops until iRST_n pulse.
- Flush abort: start a DIV, assert iFlush in cycle 3 → oStall=0 in cycle 3, state IDLE in cycle 4, no oDone; a new DivRem in cycle 4 produces a fresh oDIV_Start.
- Hold in DONE: complete a DIV with iEX_Hold=1 for 3 cycles → single oDone pulse, oStall=0 throughout, no second oDIV_Start; IDLE after hold drops.
- Async reset mid-FPU: drop iRST_n in cycle 2 between clock edges → all outputs 0 immediately; no oDone after release.
